// File: rtl/serial_cmp_ctrl.sv
// Serial frame comparator: compares N serial a/b bit pairs and reports equality, mismatch count and first mismatch index.
// Latency: done pulses one cycle after the N-th accepted pair; every output is driven from a register.
// Backpressure: none; bit_vld qualifies each pair and gaps of any length are absorbed while RUN.

// 1-bit equality cell: eq = a XNOR b.
// Latency: combinational, zero cycles.
// Backpressure: not applicable.
module cmp1 (
    input  logic a_i,
    input  logic b_i,
    output logic eq_o
);
    assign eq_o = ~(a_i ^ b_i);
endmodule

module serial_cmp_ctrl #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bit_vld,
    input  logic          a,
    input  logic          b,
    output logic          busy,
    output logic          done,
    output logic          y,
    output logic [CW-1:0] mis_cnt,
    output logic [CW-1:0] first_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CW-1:0] NONE_IDX = CW'(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] mis_cnt_q, mis_cnt_d;
    logic [CW-1:0] first_idx_q, first_idx_d;
    logic          y_q, y_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pair_eq;

    cmp1 u_cmp1 (
        .a_i  (a),
        .b_i  (b),
        .eq_o (pair_eq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            mis_cnt_q   <= '0;
            first_idx_q <= NONE_IDX;
            y_q         <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
            first_idx_q <= first_idx_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        mis_cnt_d   = mis_cnt_q;
        first_idx_d = first_idx_q;
        y_d         = y_q;

        unique case (state_q)
            IDLE: begin
                // A pair presented alongside start belongs to no frame yet.
                if (start) begin
                    state_d     = RUN;
                    bit_cnt_d   = '0;
                    mis_cnt_d   = '0;
                    first_idx_d = NONE_IDX;
                    y_d         = 1'b1;
                end
            end
            RUN: begin
                if (bit_vld) begin
                    bit_cnt_d = bit_cnt_q + ONE;
                    if (!pair_eq) begin
                        mis_cnt_d = mis_cnt_q + ONE;
                        y_d       = 1'b0;
                        if (first_idx_q == NONE_IDX) begin
                            first_idx_d = bit_cnt_q;
                        end
                    end
                    if (bit_cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with state_q.
    assign busy_d = (state_d == RUN);
    assign done_d = (state_d == DONE);

    assign busy      = busy_q;
    assign done      = done_q;
    assign y         = y_q;
    assign mis_cnt   = mis_cnt_q;
    assign first_idx = first_idx_q;

endmodule
